timer_cntdn_hms: RTL and testbench
==================================

TIMER_CNTDN_HMS -- requirements
Module: timer_cntdn_hms

Interface
REQ-001 SHALL have parameter HR_MAX, default 23: highest legal hour preset.
REQ-002 SHALL have port CLK, input, 1: system clock, all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port tick_1hz, input, 1: one-CLK-cycle pulse once per second.
REQ-005 SHALL have port load, input, 1: capture set_hr/set_min/set_sec as the new preset.
REQ-006 SHALL have ports set_hr, set_min, set_sec, input, 8 each: binary preset values.
REQ-007 SHALL have port start, input, 1: begin or resume the countdown.
REQ-008 SHALL have port pause, input, 1: freeze the countdown.
REQ-009 SHALL have port clear, input, 1: abort, zero the count, return to IDLE.
REQ-010 SHALL have ports hr, min, sec, output, 8 each: remaining time, binary.
REQ-011 SHALL have port running, output, 1: high while in RUN.
REQ-012 SHALL have port expired, output, 1: level, high while in EXPIRED.
REQ-013 SHALL have port done_pulse, output, 1: single-cycle pulse on reaching 00:00:00.

Function
REQ-014 SHALL implement a state machine with states IDLE, ARMED, RUN, PAUSED and EXPIRED.
REQ-015 SHALL, on load in IDLE/ARMED/PAUSED/EXPIRED, register the preset on the next edge, clamping hr to HR_MAX and min/sec to 59.
REQ-016 SHALL go to ARMED when the clamped preset is non-zero, and to IDLE when it is 00:00:00.
REQ-017 SHALL ignore load while in RUN.
REQ-018 SHALL move ARMED->RUN or PAUSED->RUN on start; start SHALL be ignored in IDLE and EXPIRED.
REQ-019 SHALL move RUN->PAUSED on pause, holding the count unchanged.
REQ-020 SHALL decrement by one second per tick_1hz only in RUN, never on the cycle of the start that entered RUN.
REQ-021 SHALL decrement as: sec>0 gives sec-1; else min>0 gives min-1, sec=59; else hr-1, min=59, sec=59.
REQ-022 SHALL, on the tick that produces 00:00:00, enter EXPIRED on the same edge and assert done_pulse for exactly that one following cycle.
REQ-023 SHALL keep expired high until clear or load.
REQ-024 SHALL apply priority clear > load > pause > start > tick when inputs coincide in the same cycle.
REQ-025 SHALL ignore a tick that coincides with pause in RUN, with no decrement.
REQ-026 SHALL, on clear from any state, zero hr/min/sec, enter IDLE, and drop running/expired on the next edge.
REQ-027 SHALL never let the outputs leave their ranges: hr 0..HR_MAX, min 0..59, sec 0..59.

Reset
REQ-028 SHALL, on rst_n low, immediately set state=IDLE, hr=min=sec=0, and running=expired=done_pulse=0, regardless of CLK.
REQ-029 SHALL, after rst_n deasserts mid-countdown, require a new load and start before counting.

Structure
REQ-030 SHALL place state encoding, SEC_MAX=59 and MIN_MAX=59 in shared package timer_pkg.
REQ-031 SHALL instantiate sub-module dn_count_mod three times, one per field.
REQ-032 Each dn_count_mod SHALL be a mod-N down counter with load, enable, wrap-to-N-1 and borrow_out.
REQ-033 SHALL keep done_pulse and running registered, with no combinational input-to-output path.

Verification
REQ-034 SHALL cover: load 00:00:03, start, 3 ticks -> 00:00:02, 00:00:01, 00:00:00; expired=1; done_pulse exactly 1 cycle.
REQ-035 SHALL cover: load 01:00:00, start, 1 tick -> 00:59:59, then 3599 more ticks -> EXPIRED.
REQ-036 SHALL cover: load 30:75:99 -> hr=23, min=59, sec=59 in ARMED; load 00:00:00 -> IDLE, start ignored.
REQ-037 SHALL cover: in RUN, pause together with tick -> count unchanged, PAUSED; start -> next tick decrements.
REQ-038 SHALL cover: clear with load and start in the same cycle -> IDLE with 00:00:00.
REQ-039 SHALL cover: rst_n pulsed low mid-count -> outputs zero asynchronously; ticks after release do nothing.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and limits for the H:M:S countdown timer.
// Pure declarations; no clocked logic lives here.
package timer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_RUN     = 3'd2,
        ST_PAUSED  = 3'd3,
        ST_EXPIRED = 3'd4
    } state_e;

    localparam logic [7:0] SEC_MAX = 8'd59;
    localparam logic [7:0] MIN_MAX = 8'd59;

    function automatic logic [7:0] clamp8(input logic [7:0] v, input logic [7:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/dn_count_mod.sv
// Mod-(MAXV+1) down counter with clear, load, enable and borrow-out.
// Count updates one cycle after clr/ld/en; borrow_out is combinational (en while at zero).
module dn_count_mod #(
    parameter int W    = 8,
    parameter int MAXV = 59
) (
    input  logic         CLK,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         borrow_out
);

    localparam logic [W-1:0] ONE  = 1;
    localparam logic [W-1:0] WRAP = W'(MAXV);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (ld) begin
            cnt_d = ld_val;
        end else if (en) begin
            cnt_d = (cnt_q == '0) ? WRAP : (cnt_q - ONE);
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt        = cnt_q;
    assign borrow_out = en && (cnt_q == '0);

endmodule

// File: rtl/timer_cntdn_hms.sv
// Hours/minutes/seconds countdown timer with load/start/pause/clear control.
// Outputs change on the CLK edge after the controlling input; all outputs registered.
module timer_cntdn_hms
    import timer_pkg::*;
#(
    parameter int HR_MAX = 23
) (
    input  logic       CLK,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       load,
    input  logic [7:0] set_hr,
    input  logic [7:0] set_min,
    input  logic [7:0] set_sec,
    input  logic       start,
    input  logic       pause,
    input  logic       clear,
    output logic [7:0] hr,
    output logic [7:0] min,
    output logic [7:0] sec,
    output logic       running,
    output logic       expired,
    output logic       done_pulse
);

    localparam logic [7:0] HR_LIM = 8'(HR_MAX);

    state_e     state_q;
    logic       running_q;
    logic       expired_q;
    logic       done_q;

    logic [7:0] hr_ld_d;
    logic [7:0] min_ld_d;
    logic [7:0] sec_ld_d;
    logic       preset_nz_d;
    logic       load_ok_d;
    logic       start_ok_d;
    logic       dec_d;
    logic       at_one_d;
    logic       expire_d;
    logic       sec_borrow;
    logic       min_borrow;
    logic       hr_borrow;

    assign hr_ld_d     = clamp8(set_hr, HR_LIM);
    assign min_ld_d    = clamp8(set_min, MIN_MAX);
    assign sec_ld_d    = clamp8(set_sec, SEC_MAX);
    assign preset_nz_d = |{hr_ld_d, min_ld_d, sec_ld_d};

    // Priority chain clear > load > pause > start > tick; load is dead in RUN.
    assign load_ok_d  = !clear && load && (state_q != ST_RUN);
    assign start_ok_d = !clear && !load && !pause && start &&
                        ((state_q == ST_ARMED) || (state_q == ST_PAUSED));
    assign dec_d      = !clear && !pause && tick_1hz && (state_q == ST_RUN);

    assign at_one_d = (hr == 8'd0) && (min == 8'd0) && (sec == 8'd1);
    assign expire_d = dec_d && at_one_d;

    dn_count_mod #(.W(8), .MAXV(59)) u_sec (
        .CLK        (CLK),
        .rst_n      (rst_n),
        .clr        (clear),
        .ld         (load_ok_d),
        .ld_val     (sec_ld_d),
        .en         (dec_d),
        .cnt        (sec),
        .borrow_out (sec_borrow)
    );

    dn_count_mod #(.W(8), .MAXV(59)) u_min (
        .CLK        (CLK),
        .rst_n      (rst_n),
        .clr        (clear),
        .ld         (load_ok_d),
        .ld_val     (min_ld_d),
        .en         (sec_borrow),
        .cnt        (min),
        .borrow_out (min_borrow)
    );

    // Count is never decremented from 00:00:00, so the hour borrow is never consumed.
    dn_count_mod #(.W(8), .MAXV(HR_MAX)) u_hr (
        .CLK        (CLK),
        .rst_n      (rst_n),
        .clr        (clear),
        .ld         (load_ok_d),
        .ld_val     (hr_ld_d),
        .en         (min_borrow),
        .cnt        (hr),
        .borrow_out (hr_borrow)
    );

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
            expired_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (clear) begin
                state_q   <= ST_IDLE;
                running_q <= 1'b0;
                expired_q <= 1'b0;
            end else if (load_ok_d) begin
                state_q   <= preset_nz_d ? ST_ARMED : ST_IDLE;
                running_q <= 1'b0;
                expired_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_ARMED, ST_PAUSED: begin
                        if (start_ok_d) begin
                            state_q   <= ST_RUN;
                            running_q <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (pause) begin
                            state_q   <= ST_PAUSED;
                            running_q <= 1'b0;
                        end else if (expire_d) begin
                            state_q   <= ST_EXPIRED;
                            running_q <= 1'b0;
                            expired_q <= 1'b1;
                            done_q    <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign running    = running_q;
    assign expired    = expired_q;
    assign done_pulse = done_q;

    logic unused_ok;
    assign unused_ok = hr_borrow;

endmodule

// File: tb/tb_timer_cntdn_hms.sv
// Directed bench for timer_cntdn_hms with hand-computed expectations.
module tb_timer_cntdn_hms;

    logic       CLK;
    logic       rst_n;
    logic       tick_1hz;
    logic       load;
    logic [7:0] set_hr;
    logic [7:0] set_min;
    logic [7:0] set_sec;
    logic       start;
    logic       pause;
    logic       clear;
    logic [7:0] hr;
    logic [7:0] min;
    logic [7:0] sec;
    logic       running;
    logic       expired;
    logic       done_pulse;

    int checks = 0;
    int errors = 0;

    timer_cntdn_hms #(.HR_MAX(23)) dut (
        .CLK        (CLK),
        .rst_n      (rst_n),
        .tick_1hz   (tick_1hz),
        .load       (load),
        .set_hr     (set_hr),
        .set_min    (set_min),
        .set_sec    (set_sec),
        .start      (start),
        .pause      (pause),
        .clear      (clear),
        .hr         (hr),
        .min        (min),
        .sec        (sec),
        .running    (running),
        .expired    (expired),
        .done_pulse (done_pulse)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge with whatever inputs are set, then release all strobes.
    task automatic step();
        @(posedge CLK);
        #1;
        tick_1hz = 1'b0;
        load     = 1'b0;
        start    = 1'b0;
        pause    = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        set_hr  = h;
        set_min = m;
        set_sec = s;
        load    = 1'b1;
        step();
    endtask

    function automatic logic [31:0] hms(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        return {8'd0, h, m, s};
    endfunction

    initial begin
        rst_n = 1'b0; tick_1hz = 1'b0; load = 1'b0; start = 1'b0;
        pause = 1'b0; clear = 1'b0;
        set_hr = 8'd0; set_min = 8'd0; set_sec = 8'd0;

        #3;
        chk("rst_time", {8'd0, hr, min, sec}, hms(0, 0, 0));
        chk("rst_flags", {29'd0, running, expired, done_pulse}, 32'd0);
        @(negedge CLK);
        rst_n = 1'b1;
        step();

        // 00:00:03 down to expiry
        do_load(8'd0, 8'd0, 8'd3);
        chk("l3_sec", {24'd0, sec}, 32'd3);
        chk("l3_run", {31'd0, running}, 32'd0);
        start = 1'b1; tick_1hz = 1'b1; step();
        chk("st_run", {31'd0, running}, 32'd1);
        chk("st_nodec", {8'd0, hr, min, sec}, hms(0, 0, 3));
        tick_1hz = 1'b1; step();
        chk("t1", {8'd0, hr, min, sec}, hms(0, 0, 2));
        tick_1hz = 1'b1; step();
        chk("t2", {8'd0, hr, min, sec}, hms(0, 0, 1));
        chk("t2_done", {31'd0, done_pulse}, 32'd0);
        tick_1hz = 1'b1; step();
        chk("t3", {8'd0, hr, min, sec}, hms(0, 0, 0));
        chk("t3_flags", {29'd0, running, expired, done_pulse}, 32'b011);
        step();
        chk("done_1cyc", {31'd0, done_pulse}, 32'd0);
        chk("exp_hold", {31'd0, expired}, 32'd1);
        start = 1'b1; step();
        chk("exp_start_ign", {30'd0, running, expired}, 32'b01);

        // 01:00:00 for one full hour
        do_load(8'd1, 8'd0, 8'd0);
        chk("l1h_exp", {31'd0, expired}, 32'd0);
        chk("l1h", {8'd0, hr, min, sec}, hms(1, 0, 0));
        start = 1'b1; step();
        tick_1hz = 1'b1; step();
        chk("h_borrow", {8'd0, hr, min, sec}, hms(0, 59, 59));
        tick_1hz = 1'b1;
        repeat (3598) @(posedge CLK);
        #1;
        tick_1hz = 1'b0;
        chk("h_last", {8'd0, hr, min, sec}, hms(0, 0, 1));
        chk("h_last_exp", {31'd0, expired}, 32'd0);
        tick_1hz = 1'b1; step();
        chk("h_zero", {8'd0, hr, min, sec}, hms(0, 0, 0));
        chk("h_flags", {29'd0, running, expired, done_pulse}, 32'b011);

        // Clamping and zero preset
        do_load(8'd30, 8'd75, 8'd99);
        chk("clamp", {8'd0, hr, min, sec}, hms(23, 59, 59));
        chk("clamp_flags", {29'd0, running, expired, done_pulse}, 32'd0);
        start = 1'b1; step();
        chk("clamp_armed", {31'd0, running}, 32'd1);
        load = 1'b1; set_hr = 8'd0; set_min = 8'd0; set_sec = 8'd5; step();
        chk("run_load_ign", {8'd0, hr, min, sec}, hms(23, 59, 59));
        chk("run_load_run", {31'd0, running}, 32'd1);
        tick_1hz = 1'b1; step();
        chk("wrap_min", {8'd0, hr, min, sec}, hms(23, 59, 58));
        pause = 1'b1; step();
        do_load(8'd0, 8'd0, 8'd0);
        chk("zero_load", {8'd0, hr, min, sec}, hms(0, 0, 0));
        start = 1'b1; step();
        chk("idle_start", {31'd0, running}, 32'd0);
        tick_1hz = 1'b1; step();
        chk("idle_tick", {8'd0, hr, min, sec}, hms(0, 0, 0));

        // Pause coinciding with tick
        do_load(8'd0, 8'd2, 8'd0);
        start = 1'b1; step();
        tick_1hz = 1'b1; step();
        chk("p_pre", {8'd0, hr, min, sec}, hms(0, 1, 59));
        pause = 1'b1; tick_1hz = 1'b1; step();
        chk("p_hold", {8'd0, hr, min, sec}, hms(0, 1, 59));
        chk("p_run", {31'd0, running}, 32'd0);
        tick_1hz = 1'b1; step();
        chk("p_tick", {8'd0, hr, min, sec}, hms(0, 1, 59));
        start = 1'b1; tick_1hz = 1'b1; step();
        chk("p_resume", {8'd0, hr, min, sec}, hms(0, 1, 59));
        chk("p_resume_run", {31'd0, running}, 32'd1);
        tick_1hz = 1'b1; step();
        chk("p_dec", {8'd0, hr, min, sec}, hms(0, 1, 58));

        // Clear beats load and start
        clear = 1'b1; load = 1'b1; start = 1'b1;
        set_hr = 8'd5; set_min = 8'd5; set_sec = 8'd5;
        step();
        chk("clr_time", {8'd0, hr, min, sec}, hms(0, 0, 0));
        chk("clr_flags", {29'd0, running, expired, done_pulse}, 32'd0);

        // Asynchronous reset mid-count
        do_load(8'd0, 8'd0, 8'd10);
        start = 1'b1; step();
        tick_1hz = 1'b1; step();
        chk("r_pre", {24'd0, sec}, 32'd9);
        #1;
        rst_n = 1'b0;
        #1;
        chk("r_async_time", {8'd0, hr, min, sec}, hms(0, 0, 0));
        chk("r_async_run", {31'd0, running}, 32'd0);
        #1;
        rst_n = 1'b1;
        tick_1hz = 1'b1; step();
        tick_1hz = 1'b1; step();
        chk("r_tick", {8'd0, hr, min, sec}, hms(0, 0, 0));
        start = 1'b1; step();
        tick_1hz = 1'b1; step();
        chk("r_start", {29'd0, running, expired, done_pulse}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
